// File: rtl/mem_request_unit.sv
// mem_request_unit: load/store access stage between the ALU and the data bus.
// Issues one handshaked bus transaction per load/store, stalls the core while
// the access is outstanding and returns extended load data in DONE.
// Optional feature macro: MEMREQ_TIMEOUT_EN (abort REQ after TIMEOUT_CYCLES).
//
// state | meaning
// IDLE  | waiting for memRead/memWrite; alignment checked here
// REQ   | strobe held, bus outputs stable, waiting for bus_ack_i
// DONE  | one cycle, stall low, result/flags valid; returns to IDLE
module mem_request_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o,
  output logic        bus_fault_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_byte_en_o,
  output logic        bus_ren_o,
  output logic        bus_wen_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      state_q;
  logic [31:0] load_data_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_byte_en_q;
  logic        bus_ren_q;
  logic        bus_wen_q;
  logic        misaligned_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;

  logic        request;
  logic        misalign_d;
  logic [3:0]  byte_en_d;
  logic [31:0] wdata_d;
  logic [31:0] shifted;
  logic [31:0] load_ext_d;

`ifdef MEMREQ_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             bus_fault_q;
  assign bus_fault_o = bus_fault_q;
`else
  assign bus_fault_o = 1'b0;
`endif

  assign request = mem_read_i | mem_write_i;

  // Size decode (funct3[1:0]: 00 byte, 01 half, else word), lanes and alignment.
  always_comb begin
    misalign_d = 1'b0;
    byte_en_d  = 4'b1111;
    wdata_d    = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        byte_en_d = 4'b0001 << alu_result_i[1:0];
        wdata_d   = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        misalign_d = alu_result_i[0];
        byte_en_d  = alu_result_i[1] ? 4'b1100 : 4'b0011;
        wdata_d    = {2{store_data_i[15:0]}};
      end
      default: begin
        misalign_d = |alu_result_i[1:0];
      end
    endcase
  end

  // Lane extraction and sign/zero extension of the read data.
  always_comb begin
    shifted = bus_rdata_i >> {addr_lo_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext_d = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext_d = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext_d = {24'd0, shifted[7:0]};
      3'b101:  load_ext_d = {16'd0, shifted[15:0]};
      default: load_ext_d = shifted;
    endcase
  end

  // Access sequencer with registered bus outputs and result flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      load_data_q   <= '0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      bus_byte_en_q <= '0;
      bus_ren_q     <= 1'b0;
      bus_wen_q     <= 1'b0;
      misaligned_q  <= 1'b0;
      funct3_q      <= '0;
      addr_lo_q     <= '0;
`ifdef MEMREQ_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      bus_fault_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (request) begin
            if (misalign_d) begin
              misaligned_q <= 1'b1;
              load_data_q  <= '0;
              state_q      <= S_DONE;
            end else begin
              bus_addr_q    <= {alu_result_i[31:2], 2'b00};
              bus_byte_en_q <= byte_en_d;
              bus_wdata_q   <= wdata_d;
              funct3_q      <= funct3_i;
              addr_lo_q     <= alu_result_i[1:0];
              bus_ren_q     <= ~mem_write_i;
              bus_wen_q     <= mem_write_i;
`ifdef MEMREQ_TIMEOUT_EN
              tmo_cnt_q     <= '0;
`endif
              state_q       <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus_ack_i) begin
            if (bus_ren_q) load_data_q <= load_ext_d;
            bus_ren_q <= 1'b0;
            bus_wen_q <= 1'b0;
            state_q   <= S_DONE;
          end
`ifdef MEMREQ_TIMEOUT_EN
          else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus_ren_q   <= 1'b0;
            bus_wen_q   <= 1'b0;
            bus_fault_q <= 1'b1;
            load_data_q <= '0;
            state_q     <= S_DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        S_DONE: begin
          misaligned_q <= 1'b0;
`ifdef MEMREQ_TIMEOUT_EN
          bus_fault_q  <= 1'b0;
`endif
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall_o       = ((state_q == S_IDLE) && request) || (state_q == S_REQ);
  assign load_data_o   = load_data_q;
  assign misaligned_o  = misaligned_q;
  assign bus_addr_o    = bus_addr_q;
  assign bus_wdata_o   = bus_wdata_q;
  assign bus_byte_en_o = bus_byte_en_q;
  assign bus_ren_o     = bus_ren_q;
  assign bus_wen_o     = bus_wen_q;

endmodule

// File: tb/tb_mem_request_unit.sv
// Scoreboard bench for mem_request_unit: expected results are queued when an
// access is issued and compared when the DUT reaches DONE.
module tb_mem_request_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result, store_data, bus_rdata;
  logic        mem_read, mem_write, bus_ack;
  logic [2:0]  funct3;
  logic        stall, misaligned, bus_fault, bus_ren, bus_wen;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [3:0]  bus_byte_en;

  mem_request_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .alu_result_i(alu_result), .store_data_i(store_data),
    .mem_read_i(mem_read), .mem_write_i(mem_write), .funct3_i(funct3),
    .stall_o(stall), .load_data_o(load_data), .misaligned_o(misaligned),
    .bus_fault_o(bus_fault), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
    .bus_byte_en_o(bus_byte_en), .bus_ren_o(bus_ren), .bus_wen_o(bus_wen),
    .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] load;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ren, wen, mis, fault;
    int          stall_n, req_n;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_load = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [31:0] rdd,
                                 input int ack_at, input logic [31:0] prev);
    exp_t e;
    int   sz;
    logic [7:0]  b;
    logic [15:0] h;
    logic        tmo;
    case (f3)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      default:        sz = 4;
    endcase
    e.addr  = {a[31:2], 2'b00};
    e.ren   = !wr;
    e.wen   = wr;
    e.fault = 1'b0;
    e.mis   = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
    if (sz == 1) begin
      e.be = (a[1:0] == 2'd0) ? 4'b0001 : (a[1:0] == 2'd1) ? 4'b0010 :
             (a[1:0] == 2'd2) ? 4'b0100 : 4'b1000;
      e.wdata = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
    end else if (sz == 2) begin
      e.be    = a[1] ? 4'b1100 : 4'b0011;
      e.wdata = {sd[15:0], sd[15:0]};
    end else begin
      e.be    = 4'b1111;
      e.wdata = sd;
    end
    case (a[1:0])
      2'd0: b = rdd[7:0];
      2'd1: b = rdd[15:8];
      2'd2: b = rdd[23:16];
      default: b = rdd[31:24];
    endcase
    h = a[1] ? rdd[31:16] : rdd[15:0];
    e.load = prev;
    if (!wr) begin
      case (f3)
        3'b000:  e.load = b[7] ? {24'hFFFFFF, b} : {24'h0, b};
        3'b100:  e.load = {24'h0, b};
        3'b001:  e.load = h[15] ? {16'hFFFF, h} : {16'h0, h};
        3'b101:  e.load = {16'h0, h};
        default: e.load = rdd;
      endcase
    end
    e.req_n   = ack_at;
    e.stall_n = ack_at + 1;
`ifdef MEMREQ_TIMEOUT_EN
    tmo = (ack_at == 0) || (ack_at > TMO);
`else
    tmo = 1'b0;
`endif
    if (tmo) begin
      e.fault   = 1'b1;
      e.load    = 32'h0;
      e.req_n   = TMO;
      e.stall_n = TMO + 1;
    end
    if (e.mis) begin
      e.load    = 32'h0;
      e.req_n   = 0;
      e.stall_n = 1;
    end
    return e;
  endfunction

  // Issue one access at an IDLE sample point and run it to completion.
  task automatic do_access(input logic wr, input logic rd, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rdd, input int ack_at);
    exp_t e, g;
    int   req_n, stall_n;
    bit   done;
    e = model(wr, f3, a, sd, rdd, ack_at, last_load);
    sb.push_back(e);
    last_load = e.load;
    mem_write = wr; mem_read = rd; funct3 = f3; alu_result = a;
    store_data = sd; bus_rdata = rdd; bus_ack = 1'b0;
    #1;
    stall_n = stall ? 1 : 0;
    req_n = 0;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk); #1;
      if (bus_ren || bus_wen) begin
        req_n++;
        if (stall) stall_n++;
        g = sb[0];
        chk("req_addr", bus_addr, g.addr);
        if (req_n == 1) begin
          chk("req_wdata", bus_wdata, g.wdata);
          chk("req_be", {28'h0, bus_byte_en}, {28'h0, g.be});
          chk("req_ren", {31'h0, bus_ren}, {31'h0, g.ren});
          chk("req_wen", {31'h0, bus_wen}, {31'h0, g.wen});
        end
        bus_ack = (req_n == ack_at);
      end else if (!stall) begin
        done = 1;
        bus_ack = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        g = sb.pop_front();
        chk("done_load", load_data, g.load);
        chk("done_mis", {31'h0, misaligned}, {31'h0, g.mis});
        chk("done_fault", {31'h0, bus_fault}, {31'h0, g.fault});
        chk("stall_cycles", stall_n, g.stall_n);
        chk("req_cycles", req_n, g.req_n);
      end else begin
        stall_n++;
      end
    end
    if (!done) begin
      chk("done_reached", 32'd0, 32'd1);
      bus_ack = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(posedge clk); #1;
    chk("idle_mis_clr", {31'h0, misaligned}, 32'h0);
    chk("idle_fault_clr", {31'h0, bus_fault}, 32'h0);
    chk("idle_stall", {31'h0, stall}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; mem_read = 0; mem_write = 0; funct3 = 0; alu_result = 0;
    store_data = 0; bus_rdata = 0; bus_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_load", load_data, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_be", {28'h0, bus_byte_en}, 32'h0);
    chk("rst_strobes", {30'h0, bus_ren, bus_wen}, 32'h0);
    chk("rst_flags", {30'h0, misaligned, bus_fault}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    rst = 1'b0;

    //        wr  rd  f3      addr          store         rdata         ack
    do_access(0, 1, 3'b010, 32'h0000_0100, 32'h0,         32'hDEADBEEF, 1);
    do_access(0, 1, 3'b000, 32'h0000_0103, 32'h0,         32'h80112233, 1);
    do_access(0, 1, 3'b100, 32'h0000_0103, 32'h0,         32'h80112233, 1);
    do_access(1, 0, 3'b001, 32'h0000_0202, 32'h0000ABCD,  32'h0,        3);
    do_access(0, 1, 3'b010, 32'h0000_0101, 32'h0,         32'h12345678, 1);
    do_access(0, 1, 3'b001, 32'h0000_0101, 32'h0,         32'h12345678, 1);
    do_access(0, 1, 3'b001, 32'h0000_0102, 32'h0,         32'h80011234, 2);
    do_access(0, 1, 3'b101, 32'h0000_0102, 32'h0,         32'h80011234, 1);
    do_access(1, 1, 3'b000, 32'h0000_0001, 32'h12345678,  32'hFFFFFFFF, 1);
    do_access(1, 0, 3'b010, 32'h0000_0010, 32'hCAFEF00D,  32'h0,        1);
    do_access(0, 1, 3'b000, 32'h0000_0002, 32'h0,         32'h007F0000, 1);
    do_access(0, 1, 3'b011, 32'h0000_0008, 32'h0,         32'h5A5AA5A5, 1);
    do_access(0, 1, 3'b111, 32'h0000_0006, 32'h0,         32'h0,        1);
    do_access(0, 1, 3'b101, 32'h0000_0081, 32'h0,         32'hFFFF0000, 1);
    do_access(0, 1, 3'b010, 32'h0000_0040, 32'h0,         32'h0BADF00D, 3);

    // Ack while idle with no request has no effect.
    bus_ack = 1'b1;
    @(posedge clk); #1;
    chk("stray_ack_strobes", {30'h0, bus_ren, bus_wen}, 32'h0);
    chk("stray_ack_load", load_data, last_load);
    bus_ack = 1'b0;

    // Reset on the third REQ cycle of a slow load; later ack ignored.
    mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h300; bus_rdata = 32'h11112222;
    #1;
    chk("rstpulse_idle_stall", {31'h0, stall}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rstpulse_ren", {31'h0, bus_ren}, 32'h1);
    end
    rst = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    last_load = 32'h0;
    chk("rstpulse_strobes", {30'h0, bus_ren, bus_wen}, 32'h0);
    chk("rstpulse_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    bus_ack = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("late_ack_strobes", {30'h0, bus_ren, bus_wen}, 32'h0);
    chk("late_ack_load", load_data, 32'h0);
    chk("late_ack_stall", {31'h0, stall}, 32'h0);

`ifdef MEMREQ_TIMEOUT_EN
    do_access(0, 1, 3'b010, 32'h0000_0400, 32'h0, 32'h77778888, 0);
    do_access(0, 1, 3'b010, 32'h0000_0404, 32'h0, 32'h77778888, TMO);
`endif
    do_access(0, 1, 3'b000, 32'h0000_0501, 32'h0, 32'h0000C300, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_request_unit.md
# mem_request_unit

Load/store access stage directly downstream of the ALU. Takes the ALU's computed effective address plus the store operand and issues one handshaked data-bus transaction per load/store instruction. Stalls the core until the access completes, and returns byte/half/word load data already sign- or zero-extended for writeback. Checks alignment before touching the bus.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum REQ-state cycles without `busAck` before abort. Used only with the timeout feature compiled in.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `aluResult` input 32: effective address from the ALU.
- `storeData` input 32: rs2 value for stores.
- `memRead` input 1: current instruction is a load.
- `memWrite` input 1: current instruction is a store. Takes priority if both are high.
- `funct3` input 3: access size and sign. 000 B, 001 H, 010 W, 100 BU, 101 HU. Any other code is treated as W.
- `stall` output 1: core must hold the current instruction.
- `loadData` output 32: extended load result, valid in DONE.
- `misaligned` output 1: high in DONE when the access was rejected for alignment.
- `busFault` output 1: high in DONE when the access timed out.
- `busAddr` output 32: word address; `aluResult` with [1:0] forced to 0.
- `busWData` output 32: lane-replicated store data.
- `busByteEn` output 4: active byte lanes.
- `busRen` output 1: read strobe.
- `busWen` output 1: write strobe.
- `busRData` input 32: read data, sampled when `busAck` is high.
- `busAck` input 1: transaction complete.

## Operation
- States: IDLE, REQ, DONE.
- **IDLE**
  - Request = `memRead | memWrite`.
  - Aligned request: latch address, byte enables, store data and `funct3`; go to REQ.
  - Misaligned request: go to DONE with `misaligned=1`, `loadData=0`, no bus activity.
  - Misaligned means: H/HU with addr[0]=1, or W with addr[1:0]≠0.
- **REQ**
  - `busRen` or `busWen` held high, all bus outputs stable, until `busAck`.
  - On `busAck`: capture extended read data into `loadData` (loads only), clear strobes, go to DONE.
- **DONE**
  - One cycle with `stall=0`; the core advances.
  - `memRead`/`memWrite` are ignored here because they still belong to the finished instruction.
  - Unconditionally returns to IDLE.
- **Byte enables**
  - B: `4'b0001 << addr[1:0]`.
  - H: `4'b0011` if addr[1]=0, else `4'b1100`.
  - W: `4'b1111`.
- **Store data**
  - SB: byte replicated to all four lanes.
  - SH: halfword replicated to both halves.
  - SW: unchanged.
- **Load extraction**
  - Shift: `busRData >> (8*addr[1:0])`.
  - Extension: B/H sign-extend from bit 7/15; BU/HU zero-extend; W unchanged.
- **Stall**
  - Combinational: `(IDLE & request) | REQ`. Deasserted in DONE.
- **Edge rules**
  - `busAck` outside REQ is ignored.
  - `busAck` in the same cycle the strobe first rises is legal; REQ lasts one cycle.

## Timing
- Reset values: state IDLE; `loadData`, `busAddr`, `busWData` all 0; `busByteEn`=0; `busRen`, `busWen`, `misaligned`, `busFault` all 0.
- Bus strobes are registered and rise on the edge after the request is seen in IDLE.
- Minimum latency with ack on the first REQ cycle: 3 cycles (IDLE, REQ, DONE). Each extra ack wait adds one cycle.
- Misaligned access: 2 cycles (IDLE, DONE).
- `misaligned` and `busFault` are high only in DONE, and clear on entry to IDLE.
- `rst` high in any state returns the block to IDLE on that edge and drops strobes the same edge. A late `busAck` after reset is ignored.

## Configuration
- Macro: `MEMREQ_TIMEOUT_EN`.
- Defined:
  - An 8-bit-or-wider counter clears on REQ entry and increments each REQ cycle without ack.
  - When the count reaches `TIMEOUT_CYCLES`, strobes drop and the block goes to DONE with `busFault=1` and `loadData=0`.
  - Ack on the final counted cycle wins over timeout.
- Undefined:
  - REQ waits indefinitely.
  - `busFault` is tied to 0 and no counter is built.

## Test plan
- LW at `0x100` with `busRData=0xDEADBEEF`, ack on first REQ cycle: `busByteEn=1111`, `loadData=0xDEADBEEF` in DONE, `stall` high exactly 2 cycles.
- LB at `0x103` with `busRData=0x80112233`: `loadData=0xFFFFFF80`. LBU at the same address: `loadData=0x00000080`.
- SH at `0x202` with `storeData=0x0000ABCD`: `busWData=0xABCDABCD`, `busByteEn=1100`, `busAddr=0x200`, `busWen` high until ack.
- LW at `0x101`: no strobe, `misaligned=1` in DONE, `stall` high 1 cycle. LH at `0x101` produces the same result.
- Ack delayed 5 cycles with `rst` pulsed on the 3rd REQ cycle: strobes drop on the next edge, state is IDLE, the later ack is ignored.
- With `MEMREQ_TIMEOUT_EN` and `TIMEOUT_CYCLES=4`, never acking: `busFault=1` in DONE after 4 REQ cycles. Ack on the 4th REQ cycle gives `busFault=0`.
